jtlabrun_colmix: RTL and testbench
==================================

# jtlabrun_colmix

Palette RAM and colour mixer for Labyrinth Runner, downstream of the main CPU block. It holds the 256-byte palette the CPU writes through its palette window (`pal_cs`) and returns read-back data on `pal_dout`. It converts the 7-bit colour index from the tilemap/sprite chip into 5:5:5 RGB. Blanking signals are delayed to stay aligned with the RGB output.

## Interface
Parameters:
- `BLANK_DLY`, 2: pixel-clock delay applied to `LHBL`/`LVBL`; must equal the colour-path latency.

Ports:
- `clk` in 1: 24 MHz system clock.
- `rst` in 1: reset, synchronous, active-high.
- `cpu_cen` in 1: CPU bus strobe, 3 MHz.
- `pxl_cen` in 1: pixel strobe, 6 MHz.
- `pal_cs` in 1: palette window select.
- `cpu_rnw` in 1: 1 = read, 0 = write.
- `cpu_addr` in 8: byte address within the palette (CPU A[7:0]); upper window bits are mirrored.
- `cpu_dout` in 8: CPU write data.
- `pal_dout` out 8: read-back data, registered.
- `pxl` in 7: colour index from the GFX chip.
- `LHBL`, `LVBL` in 1: blanking inputs, active-low.
- `red`, `green`, `blue` out 5: colour outputs.
- `LHBL_dly`, `LVBL_dly` out 1: delayed blanking outputs.

## Operation
- Storage is two 128×8 RAMs:
  - even RAM (`cpu_addr[0]`=0) holds `{x,B[4:0],G[4:3]}`;
  - odd RAM holds `{G[2:0],R[4:0]}`;
  - RAM index is `cpu_addr[7:1]`.
- CPU write:
  - occurs on the `clk` edge where `pal_cs & ~cpu_rnw & cpu_cen`;
  - only the RAM selected by `cpu_addr[0]` is written.
- CPU read: `pal_dout` is updated every `clk` with the byte at `cpu_addr`. It is valid by the next `cpu_cen`.
- Video path, advancing only on `pxl_cen`:
  - S1: latch `pxl`; read both RAMs at index `pxl`.
  - S2: assemble `{B,G,R}` from the two bytes and register it. If the S1-aligned blanking (`LHBL & LVBL`) is low, register zero instead.
- `LHBL`/`LVBL` pass through a `BLANK_DLY`-deep shift register clocked by `pxl_cen`.
- The video port is read-only. The CPU port and video port never conflict: the RAMs are true dual-port.

## Timing
- Reset values: `red`/`green`/`blue`=0, `LHBL_dly`/`LVBL_dly`=0, `pal_dout`=0, blanking shift register all 0. RAM contents are not cleared.
- Colour latency: 2 `pxl_cen` ticks from `pxl` to RGB, identical to the blanking delay.
- Write-to-visible: a write is used by the first S1 after the write edge.
- Simultaneous CPU write and S1 read of the same entry: S1 returns the old byte, which is read-before-write.
- Reset mid-line: the pipeline outputs 0 with blanking low until `BLANK_DLY` ticks after release.

## Configuration
- `JTLABRUN_PALBUF_EN` defined:
  - adds a second (active) pair of RAMs. CPU writes and `pal_dout` use the shadow pair; video reads the active pair.
  - On the `pxl_cen` tick where `LVBL` falls, a copy FSM goes IDLE→COPY.
  - COPY moves one index per `clk` (both bytes), with the pointer running 0→127. After index 127 it returns to IDLE, so a copy takes 128 `clk`.
  - A new `LVBL` fall during COPY is ignored.
  - A CPU write to an index already copied lands in the next frame. A write to a not-yet-copied index appears this frame.
  - Reset forces IDLE with the pointer at 0.
- Undefined: a single RAM pair, with the CPU writing directly to the video-visible palette. No copy FSM is present.

## Test plan
- Write 0x7C to addr 0x10 and 0x1F to addr 0x11, then drive `pxl`=0x08 with blanking high → two `pxl_cen` later `red`=0x1F, `green`=0x00, `blue`=0x1F.
- Write 0xA5 to addr 0x33 → a CPU read of 0x33 returns 0xA5 on the next `cpu_cen`. Writing addr 0x32 leaves 0x33 unchanged.
- Drive `LHBL`=0 while `pxl` points to a non-zero colour → RGB=0 for exactly the cycles where `LHBL_dly`=0.
- Assert `rst` for 4 `clk` mid-line → all outputs 0, then valid colours resume 2 `pxl_cen` after release.
- `JTLABRUN_PALBUF_EN`: write entry 0x05 (both bytes) mid-frame → video still shows the old colour until `LVBL` falls; 128 `clk` later it shows the new colour.
- `JTLABRUN_PALBUF_EN`: write index 0x00 at copy step 10 → not visible until the next frame. Write index 0x7F at step 10 → visible this frame.

Source files
------------

// File: rtl/jtlabrun_colmix.sv
// Labyrinth Runner palette RAM and colour mixer: CPU palette window, 7-bit index to 5:5:5 RGB.
// Optional JTLABRUN_PALBUF_EN: shadow/active palette pair with a copy on each vertical blank.
module jtlabrun_colmix #(
  parameter int BLANK_DLY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_cen,
  input  logic       pxl_cen,
  input  logic       pal_cs,
  input  logic       cpu_rnw,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_dout,
  output logic [7:0] pal_dout,
  input  logic [6:0] pxl,
  input  logic       LHBL,
  input  logic       LVBL,
  output logic [4:0] red,
  output logic [4:0] green,
  output logic [4:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);

  logic       w_cpuWe;
  logic [6:0] w_cpuIdx;
  logic [7:0] r_palDout;
  logic [6:0] r_vidEven;
  logic [7:0] r_vidOdd;
  logic       r_blankS1;
  logic [4:0] r_red;
  logic [4:0] r_green;
  logic [4:0] r_blue;
  logic [BLANK_DLY-1:0] r_hblSr;
  logic [BLANK_DLY-1:0] r_vblSr;

  assign w_cpuWe  = pal_cs & ~cpu_rnw & cpu_cen;
  assign w_cpuIdx = cpu_addr[7:1];

`ifdef JTLABRUN_PALBUF_EN
  typedef enum logic {
    IDLE,
    COPY
  } copyState_t;

  // CPU side sees the shadow pair; video only ever reads the active pair
  logic [7:0] r_shEven  [0:127];
  logic [7:0] r_shOdd   [0:127];
  logic [6:0] r_actEven [0:127];
  logic [7:0] r_actOdd  [0:127];

  copyState_t r_state;
  copyState_t w_stateNext;
  logic [6:0] r_copyPtr;
  logic [6:0] w_copyPtrNext;
  logic       w_copyWe;
  logic       r_lvblLast;
  logic       w_lvblFall;

  always_ff @(posedge clk) begin
    if (w_cpuWe && !cpu_addr[0]) r_shEven[w_cpuIdx] <= cpu_dout;
  end

  always_ff @(posedge clk) begin
    if (w_cpuWe && cpu_addr[0]) r_shOdd[w_cpuIdx] <= cpu_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) r_palDout <= 8'd0;
    else     r_palDout <= cpu_addr[0] ? r_shOdd[w_cpuIdx] : r_shEven[w_cpuIdx];
  end

  always_ff @(posedge clk) begin
    if (rst)          r_lvblLast <= 1'b0;
    else if (pxl_cen) r_lvblLast <= LVBL;
  end

  assign w_lvblFall = pxl_cen & r_lvblLast & ~LVBL;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_copyPtr <= 7'd0;
    end else begin
      r_state   <= w_stateNext;
      r_copyPtr <= w_copyPtrNext;
    end
  end

  // One index per clk; a fresh LVBL fall while copying is ignored
  always_comb begin
    w_stateNext   = r_state;
    w_copyPtrNext = r_copyPtr;
    w_copyWe      = 1'b0;
    case (r_state)
      IDLE: begin
        w_copyPtrNext = 7'd0;
        if (w_lvblFall) w_stateNext = COPY;
      end
      COPY: begin
        w_copyWe      = 1'b1;
        w_copyPtrNext = r_copyPtr + 7'd1;
        if (r_copyPtr == 7'd127) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_copyWe) r_actEven[r_copyPtr] <= r_shEven[r_copyPtr][6:0];
  end

  always_ff @(posedge clk) begin
    if (w_copyWe) r_actOdd[r_copyPtr] <= r_shOdd[r_copyPtr];
  end

  always_ff @(posedge clk) begin
    if (pxl_cen) begin
      r_vidEven <= r_actEven[pxl];
      r_vidOdd  <= r_actOdd[pxl];
    end
  end
`else
  logic [7:0] r_ramEven [0:127];
  logic [7:0] r_ramOdd  [0:127];

  always_ff @(posedge clk) begin
    if (w_cpuWe && !cpu_addr[0]) r_ramEven[w_cpuIdx] <= cpu_dout;
  end

  always_ff @(posedge clk) begin
    if (w_cpuWe && cpu_addr[0]) r_ramOdd[w_cpuIdx] <= cpu_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) r_palDout <= 8'd0;
    else     r_palDout <= cpu_addr[0] ? r_ramOdd[w_cpuIdx] : r_ramEven[w_cpuIdx];
  end

  // Non-blocking read gives the old byte when the CPU writes the same entry
  always_ff @(posedge clk) begin
    if (pxl_cen) begin
      r_vidEven <= r_ramEven[pxl][6:0];
      r_vidOdd  <= r_ramOdd[pxl];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)          r_blankS1 <= 1'b0;
    else if (pxl_cen) r_blankS1 <= LHBL & LVBL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_red   <= 5'd0;
      r_green <= 5'd0;
      r_blue  <= 5'd0;
    end else if (pxl_cen) begin
      if (r_blankS1) begin
        r_blue  <= r_vidEven[6:2];
        r_green <= {r_vidEven[1:0], r_vidOdd[7:5]};
        r_red   <= r_vidOdd[4:0];
      end else begin
        r_red   <= 5'd0;
        r_green <= 5'd0;
        r_blue  <= 5'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hblSr <= '0;
      r_vblSr <= '0;
    end else if (pxl_cen) begin
      r_hblSr[0] <= LHBL;
      r_vblSr[0] <= LVBL;
      for (int i = 1; i < BLANK_DLY; i++) begin
        r_hblSr[i] <= r_hblSr[i-1];
        r_vblSr[i] <= r_vblSr[i-1];
      end
    end
  end

  assign pal_dout = r_palDout;
  assign red      = r_red;
  assign green    = r_green;
  assign blue     = r_blue;
  assign LHBL_dly = r_hblSr[BLANK_DLY-1];
  assign LVBL_dly = r_vblSr[BLANK_DLY-1];

endmodule

// File: tb/tb_jtlabrun_colmix.sv
// Directed self-checking bench for jtlabrun_colmix; palette-buffer scenarios need JTLABRUN_PALBUF_EN.
module tb_jtlabrun_colmix;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_cen;
  logic       pxl_cen;
  logic       pal_cs;
  logic       cpu_rnw;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_dout;
  logic [7:0] pal_dout;
  logic [6:0] pxl;
  logic       LHBL;
  logic       LVBL;
  logic [4:0] red;
  logic [4:0] green;
  logic [4:0] blue;
  logic       LHBL_dly;
  logic       LVBL_dly;

  int checks   = 0;
  int failures = 0;

  jtlabrun_colmix #(.BLANK_DLY(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_cen  (cpu_cen),
    .pxl_cen  (pxl_cen),
    .pal_cs   (pal_cs),
    .cpu_rnw  (cpu_rnw),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .pal_dout (pal_dout),
    .pxl      (pxl),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .LHBL_dly (LHBL_dly),
    .LVBL_dly (LVBL_dly)
  );

  always #5 clk = ~clk;

  task automatic clkStep();
    @(posedge clk);
    #1;
  endtask

  // One pixel strobe followed by three idle clocks (6 MHz out of 24 MHz)
  task automatic pxlTick();
    pxl_cen = 1'b1;
    clkStep();
    pxl_cen = 1'b0;
    repeat (3) clkStep();
  endtask

  task automatic cpuWrite(input logic [7:0] a, input logic [7:0] d);
    pal_cs   = 1'b1;
    cpu_rnw  = 1'b0;
    cpu_addr = a;
    cpu_dout = d;
    cpu_cen  = 1'b1;
    clkStep();
    cpu_cen  = 1'b0;
    pal_cs   = 1'b0;
    cpu_rnw  = 1'b1;
  endtask

  task automatic cpuRead(input logic [7:0] a);
    pal_cs   = 1'b1;
    cpu_rnw  = 1'b1;
    cpu_addr = a;
    cpu_cen  = 1'b1;
    clkStep();
    cpu_cen  = 1'b0;
    pal_cs   = 1'b0;
  endtask

  task automatic writeEntry(input logic [6:0] idx, input logic [7:0] ev, input logic [7:0] od);
    cpuWrite({idx, 1'b0}, ev);
    cpuWrite({idx, 1'b1}, od);
  endtask

  task automatic vblankCopy();
    LVBL = 1'b1;
    pxlTick();
    LVBL = 1'b0;
    pxlTick();
    LVBL = 1'b1;
    repeat (132) clkStep();
  endtask

  task automatic makeVisible();
`ifdef JTLABRUN_PALBUF_EN
    vblankCopy();
`endif
  endtask

  task automatic showColour(input logic [6:0] p, output logic [4:0] r, output logic [4:0] g,
                            output logic [4:0] b);
    pxl  = p;
    LHBL = 1'b1;
    LVBL = 1'b1;
    pxlTick();
    pxlTick();
    r = red;
    g = green;
    b = blue;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) clkStep();
    checks += 6;
    if (red !== 5'd0)      begin failures++; $display("[TB] FAIL reset_red got=%h exp=00", red); end
    if (green !== 5'd0)    begin failures++; $display("[TB] FAIL reset_green got=%h exp=00", green); end
    if (blue !== 5'd0)     begin failures++; $display("[TB] FAIL reset_blue got=%h exp=00", blue); end
    if (LHBL_dly !== 1'b0) begin failures++; $display("[TB] FAIL reset_lhbl got=%b exp=0", LHBL_dly); end
    if (LVBL_dly !== 1'b0) begin failures++; $display("[TB] FAIL reset_lvbl got=%b exp=0", LVBL_dly); end
    if (pal_dout !== 8'd0) begin failures++; $display("[TB] FAIL reset_paldout got=%h exp=00", pal_dout); end
    rst = 1'b0;
    clkStep();
  endtask

  task automatic test_colour();
    cpuWrite(8'h10, 8'h7C);
    cpuWrite(8'h11, 8'h1F);
    LHBL = 1'b0;
    makeVisible();
    pxl  = 7'h08;
    LVBL = 1'b1;
    pxlTick();
    pxlTick();
    LHBL = 1'b1;
    pxlTick();
    checks++;
    if (red !== 5'd0) begin failures++; $display("[TB] FAIL colour_latency1 got=%h exp=00", red); end
    pxlTick();
    checks += 5;
    if (red !== 5'h1F)     begin failures++; $display("[TB] FAIL colour_red got=%h exp=1f", red); end
    if (green !== 5'h00)   begin failures++; $display("[TB] FAIL colour_green got=%h exp=00", green); end
    if (blue !== 5'h1F)    begin failures++; $display("[TB] FAIL colour_blue got=%h exp=1f", blue); end
    if (LHBL_dly !== 1'b1) begin failures++; $display("[TB] FAIL colour_lhbl got=%b exp=1", LHBL_dly); end
    if (LVBL_dly !== 1'b1) begin failures++; $display("[TB] FAIL colour_lvbl got=%b exp=1", LVBL_dly); end
  endtask

  task automatic test_readback();
    cpuWrite(8'h33, 8'hA5);
    cpuRead(8'h33);
    checks++;
    if (pal_dout !== 8'hA5) begin failures++; $display("[TB] FAIL read_33 got=%h exp=a5", pal_dout); end
    cpuWrite(8'h32, 8'h5A);
    cpuRead(8'h33);
    checks++;
    if (pal_dout !== 8'hA5) begin failures++; $display("[TB] FAIL read_33_after_32 got=%h exp=a5", pal_dout); end
    cpuRead(8'h32);
    checks++;
    if (pal_dout !== 8'h5A) begin failures++; $display("[TB] FAIL read_32 got=%h exp=5a", pal_dout); end
  endtask

  task automatic test_blanking();
    pxl  = 7'h08;
    LHBL = 1'b0;
    pxlTick();
    checks += 2;
    if (red !== 5'h1F)     begin failures++; $display("[TB] FAIL blank_t1_red got=%h exp=1f", red); end
    if (LHBL_dly !== 1'b1) begin failures++; $display("[TB] FAIL blank_t1_lhbl got=%b exp=1", LHBL_dly); end
    pxlTick();
    checks += 3;
    if (red !== 5'h00)     begin failures++; $display("[TB] FAIL blank_t2_red got=%h exp=00", red); end
    if (blue !== 5'h00)    begin failures++; $display("[TB] FAIL blank_t2_blue got=%h exp=00", blue); end
    if (LHBL_dly !== 1'b0) begin failures++; $display("[TB] FAIL blank_t2_lhbl got=%b exp=0", LHBL_dly); end
    LHBL = 1'b1;
    pxlTick();
    checks += 2;
    if (red !== 5'h00)     begin failures++; $display("[TB] FAIL blank_t3_red got=%h exp=00", red); end
    if (LHBL_dly !== 1'b0) begin failures++; $display("[TB] FAIL blank_t3_lhbl got=%b exp=0", LHBL_dly); end
    pxlTick();
    checks += 2;
    if (red !== 5'h1F)     begin failures++; $display("[TB] FAIL blank_t4_red got=%h exp=1f", red); end
    if (LHBL_dly !== 1'b1) begin failures++; $display("[TB] FAIL blank_t4_lhbl got=%b exp=1", LHBL_dly); end
  endtask

  task automatic test_reset_midline();
    pxl = 7'h08;
    pxlTick();
    rst = 1'b1;
    clkStep();
    pxl_cen = 1'b1;
    clkStep();
    pxl_cen = 1'b0;
    repeat (2) clkStep();
    checks += 6;
    if (red !== 5'd0)      begin failures++; $display("[TB] FAIL midrst_red got=%h exp=00", red); end
    if (green !== 5'd0)    begin failures++; $display("[TB] FAIL midrst_green got=%h exp=00", green); end
    if (blue !== 5'd0)     begin failures++; $display("[TB] FAIL midrst_blue got=%h exp=00", blue); end
    if (LHBL_dly !== 1'b0) begin failures++; $display("[TB] FAIL midrst_lhbl got=%b exp=0", LHBL_dly); end
    if (LVBL_dly !== 1'b0) begin failures++; $display("[TB] FAIL midrst_lvbl got=%b exp=0", LVBL_dly); end
    if (pal_dout !== 8'd0) begin failures++; $display("[TB] FAIL midrst_paldout got=%h exp=00", pal_dout); end
    rst = 1'b0;
    pxlTick();
    checks += 2;
    if (red !== 5'd0)      begin failures++; $display("[TB] FAIL midrst_t1_red got=%h exp=00", red); end
    if (LHBL_dly !== 1'b0) begin failures++; $display("[TB] FAIL midrst_t1_lhbl got=%b exp=0", LHBL_dly); end
    pxlTick();
    checks += 3;
    if (red !== 5'h1F)     begin failures++; $display("[TB] FAIL midrst_t2_red got=%h exp=1f", red); end
    if (blue !== 5'h1F)    begin failures++; $display("[TB] FAIL midrst_t2_blue got=%h exp=1f", blue); end
    if (LHBL_dly !== 1'b1) begin failures++; $display("[TB] FAIL midrst_t2_lhbl got=%b exp=1", LHBL_dly); end
  endtask

`ifdef JTLABRUN_PALBUF_EN
  task automatic test_palbuf_frame();
    logic [4:0] r, g, b;
    writeEntry(7'h05, 8'h00, 8'h1F);
    vblankCopy();
    writeEntry(7'h05, 8'h7C, 8'h00);
    showColour(7'h05, r, g, b);
    checks += 2;
    if (r !== 5'h1F) begin failures++; $display("[TB] FAIL palbuf_old_red got=%h exp=1f", r); end
    if (b !== 5'h00) begin failures++; $display("[TB] FAIL palbuf_old_blue got=%h exp=00", b); end
    vblankCopy();
    showColour(7'h05, r, g, b);
    checks += 2;
    if (r !== 5'h00) begin failures++; $display("[TB] FAIL palbuf_new_red got=%h exp=00", r); end
    if (b !== 5'h1F) begin failures++; $display("[TB] FAIL palbuf_new_blue got=%h exp=1f", b); end
  endtask

  task automatic test_palbuf_step();
    logic [4:0] r, g, b;
    writeEntry(7'h00, 8'h00, 8'h1F);
    writeEntry(7'h7F, 8'h03, 8'hE0);
    vblankCopy();
    LVBL = 1'b1;
    pxlTick();
    LVBL = 1'b0;
    pxlTick();
    writeEntry(7'h00, 8'h7C, 8'h00);
    writeEntry(7'h7F, 8'h00, 8'h1F);
    LVBL = 1'b1;
    repeat (132) clkStep();
    showColour(7'h00, r, g, b);
    checks += 2;
    if (r !== 5'h1F) begin failures++; $display("[TB] FAIL step_idx00_red got=%h exp=1f", r); end
    if (b !== 5'h00) begin failures++; $display("[TB] FAIL step_idx00_blue got=%h exp=00", b); end
    showColour(7'h7F, r, g, b);
    checks += 2;
    if (r !== 5'h1F) begin failures++; $display("[TB] FAIL step_idx7f_red got=%h exp=1f", r); end
    if (g !== 5'h00) begin failures++; $display("[TB] FAIL step_idx7f_green got=%h exp=00", g); end
    vblankCopy();
    showColour(7'h00, r, g, b);
    checks += 2;
    if (r !== 5'h00) begin failures++; $display("[TB] FAIL step_next_red got=%h exp=00", r); end
    if (b !== 5'h1F) begin failures++; $display("[TB] FAIL step_next_blue got=%h exp=1f", b); end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    cpu_cen  = 1'b0;
    pxl_cen  = 1'b0;
    pal_cs   = 1'b0;
    cpu_rnw  = 1'b1;
    cpu_addr = 8'h00;
    cpu_dout = 8'h00;
    pxl      = 7'h00;
    LHBL     = 1'b1;
    LVBL     = 1'b1;
    test_reset();
    test_colour();
    test_readback();
    test_blanking();
    test_reset_midline();
`ifdef JTLABRUN_PALBUF_EN
    test_palbuf_frame();
    test_palbuf_step();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
